// File: rtl/uart_arbiter_pkg.sv
// Shared types for the two-port uart arbiter: the buffered request record and
// the arbiter FSM states.
package uart_arbiter_pkg;

    localparam int UART_ADDR_W = 32;
    localparam int UART_STRB_W = 4;

    typedef struct packed {
        logic                   valid;
        logic                   instr;
        logic [UART_ADDR_W-1:0] addr;
        logic [UART_ADDR_W-1:0] wdata;
        logic [UART_STRB_W-1:0] wstrb;
    } uart_req_type;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } uart_arb_state_type;

    localparam uart_req_type UART_REQ_NONE = '0;

endpackage

// File: rtl/uart_req_slot.sv
// One pending-request buffer: latches a single-cycle request pulse and holds it
// until the arbiter reports completion for this port.
module uart_req_slot
    import uart_arbiter_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid,
    input  logic                   instr,
    input  logic [UART_ADDR_W-1:0] addr,
    input  logic [UART_ADDR_W-1:0] wdata,
    input  logic [UART_STRB_W-1:0] wstrb,
    input  logic                   clear,
    output logic                   full,
    output uart_req_type           req
);

    logic take;

    // A slot being cleared this cycle counts as free, so a new pulse is kept.
    assign take = valid && (!req.valid || clear);
    assign full = req.valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req <= UART_REQ_NONE;
        end else if (take) begin
            req.valid <= 1'b1;
            req.instr <= instr;
            req.addr  <= addr;
            req.wdata <= wdata;
            req.wstrb <= wstrb;
        end else if (clear) begin
            req.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_arbiter.sv
// Round-robin arbiter sharing one memory-mapped uart port between the core data
// side (port 0) and the debug/loader side (port 1), one transaction at a time.
module uart_arbiter
    import uart_arbiter_pkg::*;
#(
    parameter int ADDR_W  = UART_ADDR_W,
    parameter int RR_INIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    // Handshake: every *_valid and *_ready is a one-cycle pulse with no
    // back-pressure; a request is accepted into its slot if the slot is free,
    // and the matching ready pulse carries rdata in the same cycle.
    input  logic              m0_valid,
    input  logic              m0_instr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m0_wdata,
    input  logic [3:0]        m0_wstrb,
    output logic [ADDR_W-1:0] m0_rdata,
    output logic              m0_ready,
    input  logic              m1_valid,
    input  logic              m1_instr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [ADDR_W-1:0] m1_wdata,
    input  logic [3:0]        m1_wstrb,
    output logic [ADDR_W-1:0] m1_rdata,
    output logic              m1_ready,
    output logic              uart_valid,
    output logic              uart_instr,
    output logic [ADDR_W-1:0] uart_addr,
    output logic [ADDR_W-1:0] uart_wdata,
    output logic [3:0]        uart_wstrb,
    input  logic [ADDR_W-1:0] uart_rdata,
    input  logic              uart_ready,
    output logic              dbg_state
);

    localparam logic RR_INIT_BIT = (RR_INIT != 0);

    uart_arb_state_type state;
    uart_req_type       slot0_req;
    uart_req_type       slot1_req;
    uart_req_type       sel_req;
    logic               slot0_full;
    logic               slot1_full;
    logic               avail0;
    logic               avail1;
    logic               pick;
    logic               grant;
    logic               rr_ptr;

    uart_req_slot u_slot0 (
        .clk   (clk),
        .rst   (rst),
        .valid (m0_valid),
        .instr (m0_instr),
        .addr  (m0_addr),
        .wdata (m0_wdata),
        .wstrb (m0_wstrb),
        .clear (m0_ready),
        .full  (slot0_full),
        .req   (slot0_req)
    );

    uart_req_slot u_slot1 (
        .clk   (clk),
        .rst   (rst),
        .valid (m1_valid),
        .instr (m1_instr),
        .addr  (m1_addr),
        .wdata (m1_wdata),
        .wstrb (m1_wstrb),
        .clear (m1_ready),
        .full  (slot1_full),
        .req   (slot1_req)
    );

    // A slot whose ready is going out this cycle is already served; masking it
    // lets the other port be granted back-to-back without regranting this one.
    always_comb begin
        avail0  = slot0_full & ~m0_ready;
        avail1  = slot1_full & ~m1_ready;
        pick    = (avail0 & avail1) ? rr_ptr : avail1;
        sel_req = pick ? slot1_req : slot0_req;
    end

    assign dbg_state = (state == ARB_WAIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ARB_IDLE;
            grant      <= 1'b0;
            rr_ptr     <= RR_INIT_BIT;
            uart_valid <= 1'b0;
            uart_instr <= 1'b0;
            uart_addr  <= '0;
            uart_wdata <= '0;
            uart_wstrb <= '0;
            m0_ready   <= 1'b0;
            m1_ready   <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            uart_valid <= 1'b0;
            m0_ready   <= 1'b0;
            m1_ready   <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (avail0 || avail1) begin
                        grant      <= pick;
                        uart_valid <= sel_req.valid;
                        uart_instr <= sel_req.instr;
                        uart_addr  <= sel_req.addr;
                        uart_wdata <= sel_req.wdata;
                        uart_wstrb <= sel_req.wstrb;
                        state      <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    // rx reads may sit here until a byte arrives; no timeout.
                    if (uart_ready) begin
                        if (grant) begin
                            m1_ready <= 1'b1;
                            m1_rdata <= uart_rdata;
                        end else begin
                            m0_ready <= 1'b1;
                            m0_rdata <= uart_rdata;
                        end
                        rr_ptr <= ~grant;
                        state  <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_arbiter.sv
// Self-checking bench for uart_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level round-robin model.
module tb_uart_arbiter;

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    localparam int W = 70;

    logic        clk;
    logic        rst;
    logic        m0_valid, m0_instr, m0_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_valid, m1_instr, m1_ready;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        uart_valid, uart_instr, uart_ready;
    logic [31:0] uart_addr, uart_wdata, uart_rdata;
    logic [3:0]  uart_wstrb;
    logic        dbg_state;

    int             total;
    int             bad;
    logic [W-1:0]   exp_q[$];
    bit             rr_m;

    uart_arbiter #(.ADDR_W(32), .RR_INIT(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_valid   (m0_valid),
        .m0_instr   (m0_instr),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_wstrb   (m0_wstrb),
        .m0_rdata   (m0_rdata),
        .m0_ready   (m0_ready),
        .m1_valid   (m1_valid),
        .m1_instr   (m1_instr),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_wstrb   (m1_wstrb),
        .m1_rdata   (m1_rdata),
        .m1_ready   (m1_ready),
        .uart_valid (uart_valid),
        .uart_instr (uart_instr),
        .uart_addr  (uart_addr),
        .uart_wdata (uart_wdata),
        .uart_wstrb (uart_wstrb),
        .uart_rdata (uart_rdata),
        .uart_ready (uart_ready),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    function automatic txn_t rand_txn();
        txn_t t;
        t.instr = 1'($urandom_range(0, 1));
        t.addr  = $urandom;
        t.wdata = $urandom;
        t.wstrb = 4'($urandom_range(0, 15));
        return t;
    endfunction

    function automatic txn_t mk_txn(input logic instr, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [3:0] wstrb);
        txn_t t;
        t.instr = instr;
        t.addr  = addr;
        t.wdata = wdata;
        t.wstrb = wstrb;
        return t;
    endfunction

    function automatic txn_t got_txn();
        return {uart_instr, uart_addr, uart_wdata, uart_wstrb};
    endfunction

    task automatic drive_port(input bit p, input txn_t t);
        if (!p) begin
            m0_valid = 1'b1; m0_instr = t.instr; m0_addr = t.addr;
            m0_wdata = t.wdata; m0_wstrb = t.wstrb;
        end else begin
            m1_valid = 1'b1; m1_instr = t.instr; m1_addr = t.addr;
            m1_wdata = t.wdata; m1_wstrb = t.wstrb;
        end
    endtask

    task automatic clear_valids();
        m0_valid = 1'b0;
        m1_valid = 1'b0;
    endtask

    task automatic idle_inputs();
        clear_valids();
        m0_instr = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_instr = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        uart_ready = 1'b0;
        uart_rdata = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic pulse_req(input bit p0, input bit p1, input txn_t t0, input txn_t t1);
        if (p0) drive_port(1'b0, t0);
        if (p1) drive_port(1'b1, t1);
        tick();
        clear_valids();
    endtask

    task automatic respond(input logic [31:0] rd);
        uart_ready = 1'b1;
        uart_rdata = rd;
        tick();
        uart_ready = 1'b0;
        uart_rdata = $urandom;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        total++;
        if ({uart_valid, uart_instr, uart_addr, uart_wdata, uart_wstrb,
             m0_ready, m1_ready, m0_rdata, m1_rdata, dbg_state} !== '0) begin
            bad++;
            $display("FAIL reset_hold: outputs not zero, uart_valid=%b m0_ready=%b m1_ready=%b wanted all 0",
                     uart_valid, m0_ready, m1_ready);
        end
        rst = 1'b1;
        tick();
        total++;
        if ({uart_valid, m0_ready, m1_ready, m0_rdata, m1_rdata, dbg_state} !== '0) begin
            bad++;
            $display("FAIL reset_release: uart_valid=%b m0_ready=%b m1_ready=%b state=%b wanted 0",
                     uart_valid, m0_ready, m1_ready, dbg_state);
        end
    endtask

    task automatic test_single_write();
        txn_t        t0;
        logic [31:0] rd;
        apply_reset();
        t0 = mk_txn(1'b0, $urandom, 32'h41, 4'h1);
        pulse_req(1'b1, 1'b0, t0, t0);
        total++;
        if (uart_valid !== 1'b0) begin
            bad++; $display("FAIL single_early: uart_valid=%b at t+1 wanted 0", uart_valid);
        end
        tick();
        total++;
        if (uart_valid !== 1'b1 || got_txn() !== t0) begin
            bad++; $display("FAIL single_issue: valid=%b txn=%h wanted 1 %h", uart_valid, got_txn(), t0);
        end
        repeat (5) begin
            tick();
            total++;
            if (uart_valid !== 1'b0 || m0_ready !== 1'b0 || m1_ready !== 1'b0 || got_txn() !== t0) begin
                bad++;
                $display("FAIL single_wait: valid=%b r0=%b r1=%b txn=%h wanted 0 0 0 %h",
                         uart_valid, m0_ready, m1_ready, got_txn(), t0);
            end
        end
        rd = $urandom;
        respond(rd);
        total++;
        if (m0_ready !== 1'b1 || m0_rdata !== rd || m1_ready !== 1'b0 || m1_rdata !== 32'h0) begin
            bad++;
            $display("FAIL single_ready: r0=%b rd0=%h r1=%b rd1=%h wanted 1 %h 0 0",
                     m0_ready, m0_rdata, m1_ready, m1_rdata, rd);
        end
        tick();
        total++;
        if (m0_ready !== 1'b0 || uart_valid !== 1'b0 || dbg_state !== 1'b0) begin
            bad++;
            $display("FAIL single_after: r0=%b valid=%b state=%b wanted 0 0 0", m0_ready, uart_valid, dbg_state);
        end
    endtask

    task automatic test_simultaneous();
        txn_t        t0, t1;
        logic [31:0] rd0, rd1;
        apply_reset();
        for (int pass = 0; pass < 2; pass++) begin
            t0 = rand_txn();
            t1 = rand_txn();
            pulse_req(1'b1, 1'b1, t0, t1);
            tick();
            total++;
            if (uart_valid !== 1'b1 || got_txn() !== t0) begin
                bad++;
                $display("FAIL simul_first pass%0d: valid=%b txn=%h wanted 1 %h", pass, uart_valid, got_txn(), t0);
            end
            tick();
            tick();
            rd0 = $urandom;
            respond(rd0);
            total++;
            if (m0_ready !== 1'b1 || m1_ready !== 1'b0 || m0_rdata !== rd0) begin
                bad++;
                $display("FAIL simul_ready0 pass%0d: r0=%b r1=%b rd0=%h wanted 1 0 %h",
                         pass, m0_ready, m1_ready, m0_rdata, rd0);
            end
            tick();
            total++;
            if (uart_valid !== 1'b1 || got_txn() !== t1) begin
                bad++;
                $display("FAIL simul_second pass%0d: valid=%b txn=%h wanted 1 %h", pass, uart_valid, got_txn(), t1);
            end
            rd1 = $urandom;
            respond(rd1);
            total++;
            if (m1_ready !== 1'b1 || m0_ready !== 1'b0 || m1_rdata !== rd1) begin
                bad++;
                $display("FAIL simul_ready1 pass%0d: r1=%b r0=%b rd1=%h wanted 1 0 %h",
                         pass, m1_ready, m0_ready, m1_rdata, rd1);
            end
            tick();
            total++;
            if (uart_valid !== 1'b0) begin
                bad++; $display("FAIL simul_extra pass%0d: valid=%b wanted 0", pass, uart_valid);
            end
        end
    endtask

    task automatic test_read();
        txn_t t0, t1;
        apply_reset();
        t0 = mk_txn(1'b0, $urandom, $urandom, 4'h0);
        pulse_req(1'b1, 1'b0, t0, t0);
        tick();
        respond(32'h1234);
        total++;
        if (m0_ready !== 1'b1 || m0_rdata !== 32'h1234) begin
            bad++; $display("FAIL read_m0: r0=%b rd0=%h wanted 1 00001234", m0_ready, m0_rdata);
        end
        tick();
        t1 = mk_txn(1'b1, $urandom, $urandom, 4'h0);
        pulse_req(1'b0, 1'b1, t1, t1);
        tick();
        total++;
        if (uart_valid !== 1'b1 || got_txn() !== t1) begin
            bad++; $display("FAIL read_issue: valid=%b txn=%h wanted 1 %h", uart_valid, got_txn(), t1);
        end
        tick();
        respond(32'h5A);
        total++;
        if (m1_ready !== 1'b1 || m1_rdata !== 32'h5A || m0_ready !== 1'b0 || m0_rdata !== 32'h1234) begin
            bad++;
            $display("FAIL read_m1: r1=%b rd1=%h r0=%b rd0=%h wanted 1 5a 0 1234",
                     m1_ready, m1_rdata, m0_ready, m0_rdata);
        end
    endtask

    task automatic test_overrun();
        txn_t        t0, t9;
        int          n_valid;
        logic [31:0] rd;
        apply_reset();
        t0 = mk_txn(1'b0, $urandom, 32'h11, 4'hF);
        t9 = mk_txn(1'b1, $urandom, 32'h99, 4'h3);
        pulse_req(1'b1, 1'b0, t0, t0);
        pulse_req(1'b1, 1'b0, t9, t9);
        total++;
        if (uart_valid !== 1'b1 || got_txn() !== t0) begin
            bad++; $display("FAIL overrun_issue: valid=%b txn=%h wanted 1 %h", uart_valid, got_txn(), t0);
        end
        n_valid = 1;
        repeat (3) begin
            tick();
            if (uart_valid === 1'b1) n_valid++;
        end
        rd = $urandom;
        respond(rd);
        total++;
        if (m0_ready !== 1'b1 || m0_rdata !== rd) begin
            bad++; $display("FAIL overrun_ready: r0=%b rd0=%h wanted 1 %h", m0_ready, m0_rdata, rd);
        end
        repeat (6) begin
            tick();
            if (uart_valid === 1'b1) n_valid++;
        end
        total++;
        if (n_valid != 1) begin
            bad++; $display("FAIL overrun_count: uart_valid pulses=%0d wanted 1", n_valid);
        end
    endtask

    task automatic test_stale_ready();
        txn_t        t1;
        logic [31:0] rd;
        apply_reset();
        respond($urandom);
        total++;
        if (m0_ready !== 1'b0 || m1_ready !== 1'b0 || m0_rdata !== 32'h0 ||
            m1_rdata !== 32'h0 || dbg_state !== 1'b0) begin
            bad++;
            $display("FAIL stale_reset: r0=%b r1=%b rd0=%h rd1=%h state=%b wanted all 0",
                     m0_ready, m1_ready, m0_rdata, m1_rdata, dbg_state);
        end
        t1 = rand_txn();
        pulse_req(1'b0, 1'b1, t1, t1);
        tick();
        rd = $urandom;
        respond(rd);
        tick();
        respond(~rd);
        total++;
        if (m0_ready !== 1'b0 || m1_ready !== 1'b0 || m1_rdata !== rd || dbg_state !== 1'b0) begin
            bad++;
            $display("FAIL stale_after: r0=%b r1=%b rd1=%h state=%b wanted 0 0 %h 0",
                     m0_ready, m1_ready, m1_rdata, dbg_state, rd);
        end
    endtask

    task automatic test_reset_in_wait();
        txn_t t0;
        int   n_bad;
        apply_reset();
        t0 = rand_txn();
        pulse_req(1'b1, 1'b0, t0, t0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        total++;
        if ({uart_valid, uart_instr, uart_addr, uart_wdata, uart_wstrb,
             m0_ready, m1_ready, m0_rdata, m1_rdata, dbg_state} !== '0) begin
            bad++;
            $display("FAIL rstwait_clear: txn=%h state=%b wanted 0 0", got_txn(), dbg_state);
        end
        tick();
        rst = 1'b1;
        tick();
        respond($urandom);
        total++;
        if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin
            bad++; $display("FAIL rstwait_ready: r0=%b r1=%b wanted 0 0", m0_ready, m1_ready);
        end
        n_bad = 0;
        repeat (4) begin
            tick();
            if (uart_valid !== 1'b0 || m0_ready !== 1'b0) n_bad++;
        end
        total++;
        if (n_bad != 0) begin
            bad++; $display("FAIL rstwait_quiet: %0d active cycles wanted 0", n_bad);
        end
    endtask

    task automatic test_random();
        logic [1:0]   mask;
        txn_t         t0, t1;
        logic [W-1:0] exp;
        logic [31:0]  rd;
        int           lat;
        apply_reset();
        rr_m = 1'b0;
        exp_q.delete();
        for (int r = 0; r < 40; r++) begin
            mask = 2'($urandom_range(1, 3));
            t0 = rand_txn();
            t1 = rand_txn();
            // Model: a lone request is served; a pair is served rr_m first.
            if (mask == 2'b11) begin
                if (!rr_m) begin exp_q.push_back({1'b0, t0}); exp_q.push_back({1'b1, t1}); end
                else       begin exp_q.push_back({1'b1, t1}); exp_q.push_back({1'b0, t0}); end
            end else if (mask == 2'b01) begin
                exp_q.push_back({1'b0, t0});
            end else begin
                exp_q.push_back({1'b1, t1});
            end
            pulse_req(mask[0], mask[1], t0, t1);
            total++;
            if (uart_valid !== 1'b0) begin
                bad++; $display("FAIL rand_early r%0d: valid=%b wanted 0", r, uart_valid);
            end
            while (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                tick();
                total++;
                if (uart_valid !== 1'b1 || got_txn() !== exp[68:0]) begin
                    bad++;
                    $display("FAIL rand_issue r%0d: valid=%b txn=%h wanted 1 %h (port %0d)",
                             r, uart_valid, got_txn(), exp[68:0], exp[69]);
                end
                lat = $urandom_range(0, 5);
                repeat (lat) begin
                    if ($urandom_range(0, 2) == 0) drive_port(exp[69], rand_txn());
                    tick();
                    clear_valids();
                    total++;
                    if (uart_valid !== 1'b0 || m0_ready !== 1'b0 || m1_ready !== 1'b0) begin
                        bad++;
                        $display("FAIL rand_wait r%0d: valid=%b r0=%b r1=%b wanted 0 0 0",
                                 r, uart_valid, m0_ready, m1_ready);
                    end
                end
                rd = $urandom;
                respond(rd);
                total++;
                if (!exp[69]) begin
                    if (m0_ready !== 1'b1 || m1_ready !== 1'b0 || m0_rdata !== rd) begin
                        bad++;
                        $display("FAIL rand_ready0 r%0d: r0=%b r1=%b rd0=%h wanted 1 0 %h",
                                 r, m0_ready, m1_ready, m0_rdata, rd);
                    end
                end else begin
                    if (m1_ready !== 1'b1 || m0_ready !== 1'b0 || m1_rdata !== rd) begin
                        bad++;
                        $display("FAIL rand_ready1 r%0d: r1=%b r0=%b rd1=%h wanted 1 0 %h",
                                 r, m1_ready, m0_ready, m1_rdata, rd);
                    end
                end
                rr_m = ~exp[69];
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle_inputs();
        tick();
        test_reset();
        test_single_write();
        test_simultaneous();
        test_read();
        test_overrun();
        test_stale_ready();
        test_reset_in_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
